parity_check_stage: RTL and testbench

- Registered, lane-parametrised parity checker between a FIFO pop port and a downstream consumer.
- Splits each popped word into LANES equal lanes. Each lane carries its own parity bit, and the block checks every lane against the configured EVEN/ODD parity.
- Bad words are either forwarded with per-lane error flags or dropped, depending on mode.
- Keeps a saturating error counter and a sticky error flag, and buffers two words so it sustains one word per cycle under backpressure.

---
 rtl/parity_check_stage.sv | 124 ++++++++++++
 tb/tb_parity_check_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_check_stage.sv
// Registered per-lane parity checker sitting between a FIFO pop port and a
// downstream consumer. It holds two words (head register plus one skid entry),
// so it can take one word per cycle while grant_in stays high, and
// pop_grant_in depends only on registered occupancy.
module parity_check_stage #(
    parameter logic PARITY     = 1'b1,  // 1: even parity, 0: odd parity
    parameter logic P_BIT      = 1'b1,  // 1: parity bit at lane LSB, 0: at MSB
    parameter int   DATA_WIDTH = 17,
    parameter int   LANES      = 1,
    parameter logic DROP_BAD   = 1'b0,
    parameter int   ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pop_valid_out,
    output logic                  pop_grant_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  grant_in,
    output logic [DATA_WIDTH-1:0] chk_data,
    output logic [LANES-1:0]      chk_lane_err,
    input  logic                  err_clr,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic                  err_sticky
);

    localparam int LW = DATA_WIDTH / LANES;
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = 1;
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    // Reject lane geometries that cannot be split evenly or leave no data bit.
    if ((DATA_WIDTH % LANES) != 0 || LW < 2) begin : g_bad_lanes
        $error("parity_check_stage: DATA_WIDTH must split into LANES lanes of at least 2 bits");
    end

    // The check is a whole-lane XOR, so the parity bit position only needs to be legal.
    if (P_BIT !== 1'b0 && P_BIT !== 1'b1) begin : g_bad_pbit
        $error("parity_check_stage: P_BIT must be 0 or 1");
    end

    logic [LANES-1:0]      lane_odd;
    logic [LANES-1:0]      lane_err;
    logic                  word_bad;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  sk_valid;
    logic [DATA_WIDTH-1:0] sk_data;
    logic [LANES-1:0]      sk_err;
    logic [ERR_CNT_W-1:0]  cnt_base;
    logic [ERR_CNT_W-1:0]  cnt_next;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_odd[k] = ^data_out[k*LW +: LW];
    end

    // Flag lanes whose count of ones disagrees with the configured parity.
    always_comb begin
        lane_err = PARITY ? lane_odd : ~lane_odd;
        word_bad = |lane_err;
    end

    // A bad word in drop mode is still taken from the FIFO but never enqueued.
    always_comb begin
        pop_grant_in = ~(valid_out & sk_valid);
        accept       = pop_valid_out & pop_grant_in;
        push         = accept & ~(DROP_BAD & word_bad);
        pop          = valid_out & grant_in;
    end

    // Two-entry in-order buffer: the head register drives the outputs directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out    <= 1'b0;
            chk_data     <= '0;
            chk_lane_err <= '0;
            sk_valid     <= 1'b0;
            sk_data      <= '0;
            sk_err       <= '0;
        end else if (!valid_out) begin
            if (push) begin
                valid_out    <= 1'b1;
                chk_data     <= data_out;
                chk_lane_err <= lane_err;
            end
        end else if (!sk_valid) begin
            if (pop && push) begin
                chk_data     <= data_out;
                chk_lane_err <= lane_err;
            end else if (pop) begin
                valid_out <= 1'b0;
            end else if (push) begin
                sk_valid <= 1'b1;
                sk_data  <= data_out;
                sk_err   <= lane_err;
            end
        end else if (pop) begin
            chk_data     <= sk_data;
            chk_lane_err <= sk_err;
            sk_valid     <= 1'b0;
        end
    end

    // Clear takes effect before counting, so clear plus a bad word leaves a count of one.
    always_comb begin
        cnt_base = err_clr ? '0 : err_count;
        cnt_next = cnt_base;
        if (accept && word_bad && cnt_base != CNT_MAX) begin
            cnt_next = cnt_base + CNT_ONE;
        end
    end

    // Saturating error counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else begin
            err_count  <= cnt_next;
            err_sticky <= (err_sticky & ~err_clr) | (accept & word_bad);
        end
    end

endmodule

// File: tb/tb_parity_check_stage.sv
// Directed bench for parity_check_stage: three instances cover the default
// forward mode, drop mode with a 2-bit counter, and odd parity with two lanes.
module tb_parity_check_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    // Instance A: EVEN, LANES=1, DATA_WIDTH=17, forward bad words.
    logic        a_pv = 0, a_pg, a_vo, a_gr = 0, a_le, a_clr = 0, a_st;
    logic [16:0] a_d = '0, a_cd;
    logic [7:0]  a_cnt;

    parity_check_stage #(.PARITY(1'b1), .P_BIT(1'b1), .DATA_WIDTH(17), .LANES(1),
                         .DROP_BAD(1'b0), .ERR_CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .pop_valid_out(a_pv), .pop_grant_in(a_pg),
        .data_out(a_d), .valid_out(a_vo), .grant_in(a_gr), .chk_data(a_cd),
        .chk_lane_err(a_le), .err_clr(a_clr), .err_count(a_cnt), .err_sticky(a_st));

    // Instance B: EVEN, LANES=1, DATA_WIDTH=17, drop bad words, 2-bit counter.
    logic        b_pv = 0, b_pg, b_vo, b_gr = 0, b_le, b_clr = 0, b_st;
    logic [16:0] b_d = '0, b_cd;
    logic [1:0]  b_cnt;

    parity_check_stage #(.PARITY(1'b1), .P_BIT(1'b1), .DATA_WIDTH(17), .LANES(1),
                         .DROP_BAD(1'b1), .ERR_CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .pop_valid_out(b_pv), .pop_grant_in(b_pg),
        .data_out(b_d), .valid_out(b_vo), .grant_in(b_gr), .chk_data(b_cd),
        .chk_lane_err(b_le), .err_clr(b_clr), .err_count(b_cnt), .err_sticky(b_st));

    // Instance C: ODD, LANES=2, DATA_WIDTH=16.
    logic        c_pv = 0, c_pg, c_vo, c_gr = 0, c_clr = 0, c_st;
    logic [15:0] c_d = '0, c_cd;
    logic [1:0]  c_le;
    logic [7:0]  c_cnt;

    parity_check_stage #(.PARITY(1'b0), .P_BIT(1'b0), .DATA_WIDTH(16), .LANES(2),
                         .DROP_BAD(1'b0), .ERR_CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .pop_valid_out(c_pv), .pop_grant_in(c_pg),
        .data_out(c_d), .valid_out(c_vo), .grant_in(c_gr), .chk_data(c_cd),
        .chk_lane_err(c_le), .err_clr(c_clr), .err_count(c_cnt), .err_sticky(c_st));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_valid",  32'(a_vo),  32'h0);
        check("rst_data",   32'(a_cd),  32'h0);
        check("rst_lerr",   32'(a_le),  32'h0);
        check("rst_cnt",    32'(a_cnt), 32'h0);
        check("rst_sticky", 32'(a_st),  32'h0);
        check("rst_pgrant", 32'(a_pg),  32'h1);
        #11 rst = 1'b0;
        tick();

        // Good word through forward mode.
        a_gr = 1; a_pv = 1; a_d = 17'h00003;
        tick();
        a_pv = 0;
        check("good_valid", 32'(a_vo),  32'h1);
        check("good_data",  32'(a_cd),  32'h00003);
        check("good_lerr",  32'(a_le),  32'h0);
        check("good_cnt",   32'(a_cnt), 32'h0);
        tick();
        check("good_drain", 32'(a_vo),  32'h0);

        // Bad word forwarded with its flag.
        a_pv = 1; a_d = 17'h00001;
        tick();
        a_pv = 0;
        check("bad_valid",  32'(a_vo),  32'h1);
        check("bad_data",   32'(a_cd),  32'h00001);
        check("bad_lerr",   32'(a_le),  32'h1);
        check("bad_cnt",    32'(a_cnt), 32'h1);
        check("bad_sticky", 32'(a_st),  32'h1);
        tick();

        // Backpressure: A and B fill the buffer, C waits upstream.
        a_gr = 0; a_pv = 1; a_d = 17'h00003;
        check("bp_pg0", 32'(a_pg), 32'h1);
        tick();
        a_d = 17'h00005;
        check("bp_pg1", 32'(a_pg), 32'h1);
        tick();
        a_d = 17'h00006;
        check("bp_full_pg", 32'(a_pg), 32'h0);
        check("bp_head_a",  32'(a_cd), 32'h00003);
        tick();
        check("bp_hold_pg", 32'(a_pg), 32'h0);
        check("bp_hold_a",  32'(a_cd), 32'h00003);
        check("bp_hold_v",  32'(a_vo), 32'h1);
        a_gr = 1;
        tick();
        check("bp_out_b",   32'(a_cd), 32'h00005);
        check("bp_pg_open", 32'(a_pg), 32'h1);
        tick();
        a_pv = 0;
        check("bp_out_c",   32'(a_cd), 32'h00006);
        check("bp_out_cv",  32'(a_vo), 32'h1);
        tick();
        check("bp_empty",   32'(a_vo), 32'h0);

        // Clear alone.
        a_clr = 1;
        tick();
        a_clr = 0;
        check("clr_cnt",    32'(a_cnt), 32'h0);
        check("clr_sticky", 32'(a_st),  32'h0);

        // Drop mode: good, bad, good back-to-back.
        b_gr = 1; b_pv = 1; b_d = 17'h00003;
        check("drop_pg0", 32'(b_pg), 32'h1);
        tick();
        b_d = 17'h00001;
        check("drop_v0",  32'(b_vo), 32'h1);
        check("drop_d0",  32'(b_cd), 32'h00003);
        check("drop_pg1", 32'(b_pg), 32'h1);
        tick();
        b_d = 17'h00005;
        check("drop_gap", 32'(b_vo),  32'h0);
        check("drop_pg2", 32'(b_pg),  32'h1);
        check("drop_cnt", 32'(b_cnt), 32'h1);
        tick();
        b_pv = 0;
        check("drop_v1",  32'(b_vo), 32'h1);
        check("drop_d1",  32'(b_cd), 32'h00005);
        tick();
        check("drop_end", 32'(b_vo), 32'h0);

        // Four more bad words: count goes 2, 3, 3, 3.
        b_pv = 1; b_d = 17'h00001;
        tick();
        check("sat_2", 32'(b_cnt), 32'h2);
        tick();
        check("sat_3", 32'(b_cnt), 32'h3);
        tick();
        tick();
        b_pv = 0;
        check("sat_hold",  32'(b_cnt), 32'h3);
        check("sat_novld", 32'(b_vo),  32'h0);

        // Clear together with a bad word.
        b_clr = 1; b_pv = 1; b_d = 17'h00001;
        tick();
        b_clr = 0; b_pv = 0;
        check("clrbad_cnt",    32'(b_cnt), 32'h1);
        check("clrbad_sticky", 32'(b_st),  32'h1);

        // Fill both entries, then reset asynchronously mid-cycle.
        b_gr = 0; b_pv = 1; b_d = 17'h00003;
        tick();
        b_d = 17'h00005;
        tick();
        b_pv = 0;
        check("pre_rst_v",  32'(b_vo), 32'h1);
        check("pre_rst_pg", 32'(b_pg), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("arst_v",      32'(b_vo),  32'h0);
        check("arst_cnt",    32'(b_cnt), 32'h0);
        check("arst_sticky", 32'(b_st),  32'h0);
        check("arst_pg",     32'(b_pg),  32'h1);
        b_gr = 1;
        #4 rst = 1'b0;
        tick();
        check("post_rst_v", 32'(b_vo), 32'h0);

        // Odd parity, two lanes.
        c_gr = 1; c_pv = 1; c_d = 16'h0100;
        tick();
        c_d = 16'h0101;
        check("odd_lerr01", 32'(c_le),  32'h1);
        check("odd_data0",  32'(c_cd),  32'h0100);
        check("odd_cnt1",   32'(c_cnt), 32'h1);
        tick();
        c_d = 16'h0001;
        check("odd_lerr00", 32'(c_le),  32'h0);
        check("odd_cnt1b",  32'(c_cnt), 32'h1);
        tick();
        c_pv = 0;
        check("odd_lerr10", 32'(c_le),  32'h2);
        check("odd_cnt2",   32'(c_cnt), 32'h2);
        check("odd_sticky", 32'(c_st),  32'h1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
